mostrador7_mux: RTL and testbench

Multiplexed, parametrised seven-segment display controller for the irrigation controller front panel. It time-scans N_DIG common digits. It shows either the water-level view (critical/low/medium/high/error) or the irrigation-type view (drip/sprinkler), selected manually or alternated automatically. The glyph blinks on error or critical level. It sits between the level/irrigation decision logic and the physical display pins.

---
 rtl/mostrador7_mux.sv | 195 +++++++++++++++++++
 tb/tb_mostrador7_mux.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mostrador7_mux.sv
// mostrador7_mux: multiplexed seven-segment controller for the irrigation panel.
// It scans N_DIG common digits and shows either the water-level view or the
// irrigation-type view. Digit 0 carries the glyph, digit 1 carries a view tag,
// and the remaining digits are blank. All decoding runs from a per-frame input
// snapshot, so the display never tears mid-frame.
module mostrador7_mux #(
    parameter int N_DIG        = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int ALT_FRAMES   = 256,
    parameter int BLINK_FRAMES = 64
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Nv_Critico,
    input  logic             Nv_Baixo,
    input  logic             Nv_Medio,
    input  logic             Nv_Alto,
    input  logic             Err,
    input  logic             Bs,
    input  logic             Vs,
    input  logic             Sd,
    input  logic             Auto,
    output logic [6:0]       SEGs,
    output logic [N_DIG-1:0] SEG_D,
    output logic             Vista
);

    localparam int PRE_W = (SCAN_DIV > 1)     ? $clog2(SCAN_DIV)     : 1;
    localparam int IDX_W = (N_DIG > 1)        ? $clog2(N_DIG)        : 1;
    localparam int ALT_W = (ALT_FRAMES > 1)   ? $clog2(ALT_FRAMES)   : 1;
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIG - 1);
    localparam logic [ALT_W-1:0] ALT_LAST = ALT_W'(ALT_FRAMES - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

    localparam logic [6:0] GLYPH_E     = 7'h79;
    localparam logic [6:0] GLYPH_C     = 7'h39;
    localparam logic [6:0] GLYPH_B     = 7'h7C;
    localparam logic [6:0] GLYPH_N     = 7'h54;
    localparam logic [6:0] GLYPH_H     = 7'h76;
    localparam logic [6:0] GLYPH_D     = 7'h5E;
    localparam logic [6:0] GLYPH_A     = 7'h77;
    localparam logic [6:0] GLYPH_DASH  = 7'h40;
    localparam logic [6:0] TAG_LEVEL   = 7'h38;
    localparam logic [6:0] TAG_IRRIG   = 7'h50;
    localparam logic [6:0] GLYPH_BLANK = 7'h00;

    // Frame-stable copy of the status flags. The manual view select is kept
    // in view_p0, which loads on the same edge as this snapshot.
    typedef struct packed {
        logic critico;
        logic baixo;
        logic medio;
        logic alto;
        logic err;
        logic bs;
        logic vs;
    } snap_t;

    logic [PRE_W-1:0] pre_p0;
    logic [IDX_W-1:0] idx_p0;
    snap_t            snap_p0;
    logic             view_p0;
    logic [ALT_W-1:0] alt_cnt_p0;
    logic             alt_ph_p0;
    logic [BLK_W-1:0] blink_cnt_p0;
    logic             blink_on_p0;

    logic             pre_last;
    logic             idx_last;
    logic             frame_tick;
    logic             alt_ph_next;
    logic [6:0]       glyph_p0;
    logic             blank_p0;
    logic [6:0]       seg_p0;
    logic [N_DIG-1:0] seg_d_p0;

    // Level glyph with priority Err > Critico > Baixo > Medio > Alto.
    function automatic logic [6:0] level_glyph(input snap_t s);
        if (s.err)          return GLYPH_E;
        else if (s.critico) return GLYPH_C;
        else if (s.baixo)   return GLYPH_B;
        else if (s.medio)   return GLYPH_N;
        else if (s.alto)    return GLYPH_H;
        else                return GLYPH_DASH;
    endfunction

    // Irrigation glyph; both sources active at once is shown as an error.
    function automatic logic [6:0] irrig_glyph(input snap_t s);
        case ({s.bs, s.vs})
            2'b10:   return GLYPH_D;
            2'b01:   return GLYPH_A;
            2'b11:   return GLYPH_E;
            default: return GLYPH_DASH;
        endcase
    endfunction

    assign pre_last    = (pre_p0 == PRE_LAST);
    assign idx_last    = (idx_p0 == IDX_LAST);
    assign frame_tick  = pre_last && idx_last;
    assign alt_ph_next = (alt_cnt_p0 == ALT_LAST) ? ~alt_ph_p0 : alt_ph_p0;

    // ---- stage p0: scan timing, snapshot, view and blink state ----

    // Prescaler and digit index: each digit holds for SCAN_DIV cycles.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            pre_p0 <= '0;
            idx_p0 <= '0;
        end else if (pre_last) begin
            pre_p0 <= '0;
            idx_p0 <= idx_last ? '0 : idx_p0 + IDX_W'(1);
        end else begin
            pre_p0 <= pre_p0 + PRE_W'(1);
        end
    end

    // Input snapshot, refreshed only as the scan wraps back to digit 0.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            snap_p0 <= '0;
        end else if (frame_tick) begin
            snap_p0 <= '{critico: Nv_Critico, baixo: Nv_Baixo, medio: Nv_Medio,
                         alto: Nv_Alto, err: Err, bs: Bs, vs: Vs};
        end
    end

    // Alternation counter; held at the level phase whenever Auto is low.
    always_ff @(posedge Clk) begin
        if (Rst || !Auto) begin
            alt_cnt_p0 <= '0;
            alt_ph_p0  <= 1'b0;
        end else if (frame_tick) begin
            alt_cnt_p0 <= (alt_cnt_p0 == ALT_LAST) ? '0 : alt_cnt_p0 + ALT_W'(1);
            alt_ph_p0  <= alt_ph_next;
        end
    end

    // Displayed view, only ever changed on a frame tick so it never tears.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            view_p0 <= 1'b0;
        end else if (frame_tick) begin
            view_p0 <= Auto ? alt_ph_next : Sd;
        end
    end

    // Blink phase: starts ON and flips every BLINK_FRAMES frames.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            blink_cnt_p0 <= '0;
            blink_on_p0  <= 1'b1;
        end else if (frame_tick) begin
            if (blink_cnt_p0 == BLK_LAST) begin
                blink_cnt_p0 <= '0;
                blink_on_p0  <= ~blink_on_p0;
            end else begin
                blink_cnt_p0 <= blink_cnt_p0 + BLK_W'(1);
            end
        end
    end

    // Segment and digit-enable decode for the digit currently selected.
    always_comb begin
        glyph_p0 = view_p0 ? irrig_glyph(snap_p0) : level_glyph(snap_p0);
        blank_p0 = !view_p0 && (snap_p0.err || snap_p0.critico) && !blink_on_p0;
        seg_p0   = GLYPH_BLANK;
        if (idx_p0 == '0) begin
            seg_p0 = blank_p0 ? GLYPH_BLANK : glyph_p0;
        end else if (idx_p0 == IDX_W'(1)) begin
            seg_p0 = view_p0 ? TAG_IRRIG : TAG_LEVEL;
        end
        for (int i = 0; i < N_DIG; i++) begin
            seg_d_p0[i] = (idx_p0 != IDX_W'(i));
        end
    end

    // ---- stage p1: registered pin drivers ----

    // Output register: all digits dark while in reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            SEGs  <= '0;
            SEG_D <= '1;
            Vista <= 1'b0;
        end else begin
            SEGs  <= seg_p0;
            SEG_D <= seg_d_p0;
            Vista <= view_p0;
        end
    end

endmodule

// File: tb/tb_mostrador7_mux.sv
// Testbench for mostrador7_mux with a small scan configuration.
// A frame-level reference model predicts every output cycle; directed steps
// add literal expectations for the reset state and each display mode.
module tb_mostrador7_mux;

    localparam int ND    = 4;
    localparam int SD    = 2;
    localparam int AF    = 2;
    localparam int BF    = 1;
    localparam int FRAME = ND * SD;

    logic          Clk = 1'b0;
    logic          Rst = 1'b1;
    logic          Nv_Critico = 1'b0, Nv_Baixo = 1'b0, Nv_Medio = 1'b0, Nv_Alto = 1'b0;
    logic          Err = 1'b0, Bs = 1'b0, Vs = 1'b0, Sd = 1'b0, Auto = 1'b0;
    logic [6:0]    SEGs;
    logic [ND-1:0] SEG_D;
    logic          Vista;

    int n_checks = 0;
    int n_fail   = 0;

    mostrador7_mux #(
        .N_DIG(ND), .SCAN_DIV(SD), .ALT_FRAMES(AF), .BLINK_FRAMES(BF)
    ) dut (
        .Clk(Clk), .Rst(Rst),
        .Nv_Critico(Nv_Critico), .Nv_Baixo(Nv_Baixo), .Nv_Medio(Nv_Medio), .Nv_Alto(Nv_Alto),
        .Err(Err), .Bs(Bs), .Vs(Vs), .Sd(Sd), .Auto(Auto),
        .SEGs(SEGs), .SEG_D(SEG_D), .Vista(Vista)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m counts non-reset clock edges; the output after an edge shows state m.
    int         m, ticks, auto_ticks, exp_m;
    logic       s_err, s_crit, s_baixo, s_medio, s_alto, s_bs, s_vs, mview;
    logic [6:0] exp_seg;
    logic [3:0] exp_segd;
    logic       exp_vista;
    bit         model_ok = 1'b0;

    function automatic logic [6:0] model_seg(input int digit);
        logic [6:0] g;
        bit blink_on;
        if (digit >= 2) return 7'h00;
        if (digit == 1) return mview ? 7'h50 : 7'h38;
        blink_on = ((ticks / BF) % 2) == 0;
        if (mview) begin
            if (s_bs && s_vs) g = 7'h79;
            else if (s_bs)    g = 7'h5E;
            else if (s_vs)    g = 7'h77;
            else              g = 7'h40;
        end else begin
            if (s_err)        g = 7'h79;
            else if (s_crit)  g = 7'h39;
            else if (s_baixo) g = 7'h7C;
            else if (s_medio) g = 7'h54;
            else if (s_alto)  g = 7'h76;
            else              g = 7'h40;
            if ((s_err || s_crit) && !blink_on) g = 7'h00;
        end
        return g;
    endfunction

    initial begin
        int digit;
        forever begin
            @(posedge Clk);
            if (Rst) begin
                m = 0; ticks = 0; auto_ticks = 0; exp_m = -1;
                {s_err, s_crit, s_baixo, s_medio, s_alto, s_bs, s_vs} = '0;
                mview     = 1'b0;
                exp_seg   = 7'h00;
                exp_segd  = 4'b1111;
                exp_vista = 1'b0;
                model_ok  = 1'b1;
            end else begin
                exp_m     = m;
                digit     = (m / SD) % ND;
                exp_seg   = model_seg(digit);
                exp_segd  = 4'b1111;
                exp_segd[digit] = 1'b0;
                exp_vista = mview;
                m++;
                if (!Auto) auto_ticks = 0;
                if (m % FRAME == 0) begin
                    ticks++;
                    {s_err, s_crit, s_baixo, s_medio, s_alto, s_bs, s_vs} =
                        {Err, Nv_Critico, Nv_Baixo, Nv_Medio, Nv_Alto, Bs, Vs};
                    if (Auto) begin
                        auto_ticks++;
                        mview = ((auto_ticks / AF) % 2) == 1;
                    end else begin
                        mview = Sd;
                    end
                end
            end
        end
    end

    // Every-cycle comparison of the DUT against the model.
    initial begin
        forever begin
            @(negedge Clk);
            if (model_ok) begin
                check("model_segs",  SEGs,  exp_seg);
                check("model_seg_d", SEG_D, exp_segd);
                check("model_vista", Vista, exp_vista);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic next_frame();
        int n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while ((exp_m % FRAME) != 0 && n < 3 * FRAME);
        if ((exp_m % FRAME) != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_sync_timeout: got pos %0d, expected 0", exp_m % FRAME);
        end
    endtask

    task automatic skip(input int n);
        repeat (n) @(negedge Clk);
    endtask

    logic [3:0] idle_segd [8] = '{4'b1110, 4'b1110, 4'b1101, 4'b1101,
                                  4'b1011, 4'b1011, 4'b0111, 4'b0111};
    logic [6:0] idle_seg  [8] = '{7'h40, 7'h40, 7'h38, 7'h38,
                                  7'h00, 7'h00, 7'h00, 7'h00};

    initial begin
        int n;
        // Reset state
        skip(2);
        check("reset_segs",  SEGs,  7'h00);
        check("reset_seg_d", SEG_D, 4'b1111);
        check("reset_vista", Vista, 1'b0);
        Rst = 1'b0;
        skip(1);

        // Idle scan pattern, starting with the first cycle after reset
        for (int i = 0; i < 8; i++) begin
            check("idle_seg_d", SEG_D, idle_segd[i]);
            check("idle_segs",  SEGs,  idle_seg[i]);
            skip(1);
        end

        // Medio+Alto -> 'n'; clearing mid-frame holds until the next tick
        Nv_Medio = 1'b1; Nv_Alto = 1'b1;
        next_frame();
        check("medio_glyph", SEGs, 7'h54);
        Nv_Medio = 1'b0; Nv_Alto = 1'b0;
        skip(1);
        check("medio_hold", SEGs, 7'h54);
        next_frame();
        check("medio_clear", SEGs, 7'h40);

        // Irrigation view: both -> 'E', drip only -> 'd'
        Sd = 1'b1; Bs = 1'b1; Vs = 1'b1;
        next_frame();
        check("irr_both",       SEGs,  7'h79);
        check("irr_vista",      Vista, 1'b1);
        skip(2);
        check("irr_tag",        SEGs,  7'h50);
        Vs = 1'b0;
        next_frame();
        check("irr_drip",       SEGs,  7'h5E);

        // Error + critical in level view blinks digit 0, tag steady
        Sd = 1'b0; Bs = 1'b0; Err = 1'b1; Nv_Critico = 1'b1;
        next_frame();
        check("blink_on_a",  SEGs, 7'h79);
        skip(2);
        check("blink_tag_a", SEGs, 7'h38);
        next_frame();
        check("blink_off",   SEGs, 7'h00);
        skip(2);
        check("blink_tag_b", SEGs, 7'h38);
        next_frame();
        check("blink_on_b",  SEGs, 7'h79);

        // Same fault flags in irrigation view: steady drip glyph
        Sd = 1'b1; Bs = 1'b1;
        next_frame();
        check("noblink_a",     SEGs,  7'h5E);
        check("noblink_vista", Vista, 1'b1);
        next_frame();
        check("noblink_b",     SEGs,  7'h5E);

        // Automatic alternation: two frames per view
        Err = 1'b0; Nv_Critico = 1'b0; Bs = 1'b0; Sd = 1'b0;
        Nv_Baixo = 1'b1; Vs = 1'b1; Auto = 1'b1;
        next_frame();
        check("auto_f1_vista", Vista, 1'b0); check("auto_f1_seg", SEGs, 7'h7C);
        next_frame();
        check("auto_f2_vista", Vista, 1'b1); check("auto_f2_seg", SEGs, 7'h77);
        next_frame();
        check("auto_f3_vista", Vista, 1'b1); check("auto_f3_seg", SEGs, 7'h77);
        next_frame();
        check("auto_f4_vista", Vista, 1'b0); check("auto_f4_seg", SEGs, 7'h7C);
        next_frame();
        check("auto_f5_vista", Vista, 1'b0); check("auto_f5_seg", SEGs, 7'h7C);
        Auto = 1'b0;
        next_frame();
        check("manual_vista", Vista, 1'b0); check("manual_seg", SEGs, 7'h7C);
        next_frame();
        check("manual_vista_b", Vista, 1'b0);

        // Reset pulse while digit 2 is being scanned
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while ((exp_m % FRAME) != 4 && n < 3 * FRAME);
        check("rst_mid_sync", SEG_D, 4'b1011);
        Rst = 1'b1;
        skip(1);
        check("rst_mid_segs",  SEGs,  7'h00);
        check("rst_mid_seg_d", SEG_D, 4'b1111);
        check("rst_mid_vista", Vista, 1'b0);
        Rst = 1'b0;
        skip(1);
        check("restart_seg_d", SEG_D, 4'b1110);
        check("restart_segs",  SEGs,  7'h40);
        skip(3 * FRAME);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

endmodule
